dcache_resp: RTL and testbench
==============================

Name: dcache_resp

Overview:
- Data-cache responder serving the MEM stage's load/store requests.
- Direct-mapped, single-word lines, write-through, no-write-allocate.
- Serves hits from the internal array.
- Forwards load misses and all stores to backing memory over a valid/ready request channel plus a valid-only response channel.

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines).
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  MEM-stage request present.
- req_mem_op  in  2  mem_op_t: MEM_OP_NONE, MEM_OP_LW or MEM_OP_SW.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  load data; 0 for store acknowledgements.
- mem_req_valid  out  1  backing-memory request.
- mem_req_we  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  word-aligned address ([1:0]=0).
- mem_req_wdata  out  DATA_W  write data.
- mem_req_ready  in  1  backing memory accepts the request.
- mem_resp_valid  in  1  read data returning.
- mem_resp_rdata  in  DATA_W  read data.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Address split:
  - index = req_addr[INDEX_BITS+1:2]
  - tag = req_addr[ADDR_W-1:INDEX_BITS+2]
- Reset:
  - state=IDLE; all valid bits=0.
  - req_ready=1; resp_valid=0; resp_rdata=0.
  - mem_req_valid=0; mem_req_we=0; mem_req_addr=0; mem_req_wdata=0.
  - Tag and data arrays are not reset.
- Acceptance: a request is accepted on req_valid && req_ready. req_ready=1 only in IDLE.
- MEM_OP_NONE with req_valid: ignored. No response, no state change.
- States:
  - IDLE:
    - LW hit (valid && tag match): resp_valid=1, resp_rdata=line data on the next edge, stay IDLE. Back-to-back hits run at 1 per cycle.
    - LW miss: capture address, go MISS_REQ.
    - SW: if hit, update line data (tag and valid unchanged). If miss, array untouched. Capture address/data, go WR_REQ.
  - MISS_REQ: mem_req_valid=1, we=0. On mem_req_ready go MISS_WAIT and drop mem_req_valid next cycle.
  - MISS_WAIT: on mem_resp_valid:
    - Write line: valid=1, tag, data.
    - resp_valid=1 and resp_rdata=mem_resp_rdata next cycle.
    - Go IDLE.
  - WR_REQ: mem_req_valid=1, we=1. On mem_req_ready: resp_valid=1, resp_rdata=0 next cycle, go IDLE. No memory response is expected for writes.
- Latency:
  - Hit: 1 cycle.
  - Load miss: 2 cycles + request stall cycles + memory latency.
  - Store: 2 cycles minimum.
- Handshake rules:
  - mem_req_* held stable while mem_req_valid && !mem_req_ready.
  - mem_resp_valid sampled only in MISS_WAIT; ignored in all other states.
  - Backing memory must not assert mem_resp_valid in the same cycle it asserts mem_req_ready.
- resp_valid is exactly one cycle per LW/SW accepted. The requester cannot backpressure it.
- Reset mid-miss or mid-write: immediate return to IDLE with outputs per reset. No response issued. Late memory responses are ignored.
- Aliasing: an SW to the same index with a different tag leaves the cached line intact. A later LW to the cached tag returns the old data.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count and miss_count, 32 bits each, reset to 0.
  - Each increments once per accepted LW hit/miss. SW is not counted.
  - Counters wrap at 2^32-1 → 0.
- Undefined: ports and counters absent. Behaviour otherwise identical.

Decomposition:
- Shared structures package:
  - mem_op_t enum: MEM_OP_NONE=0, MEM_OP_LW=1, MEM_OP_SW=2.
  - Parameter defaults.
  - State enum dcache_state_t: IDLE, MISS_REQ, MISS_WAIT, WR_REQ.
- Sub-module dcache_line_array:
  - Valid/tag/data storage.
  - Combinational read by index; one synchronous write port.
  - Async clear of the valid bits.

Test Plan:
- Reset, then LW 0x0000_0040, memory ready=1 with 3-cycle latency returning 0xDEAD_BEEF → mem read at 0x40, resp_rdata=0xDEAD_BEEF. A repeat LW hits in 1 cycle with no mem_req.
- SW 0x40 data 0x1234_5678 after the line is cached → mem write 0x40/0x1234_5678, ack resp_rdata=0. Then LW 0x40 hits with 0x1234_5678.
- SW 0x0000_0140 (same index as 0x40, different tag) → mem write only. LW 0x40 still hits with the old data.
- mem_req_ready held low 5 cycles during a miss → mem_req_addr/we stable throughout, req_ready=0, exactly one resp_valid.
- rst pulsed in MISS_WAIT, then mem_resp_valid arrives → no resp_valid. LW to the same address misses again.
- DCACHE_STATS_EN: 1 miss, 3 hits, 1 SW → miss_count=1, hit_count=3.

Source files
------------

// File: rtl/dcache_resp_pkg.sv
// Shared types and default sizes for the dcache_resp data-cache responder.
package dcache_resp_pkg;

  localparam int unsigned INDEX_BITS_DEF = 6;
  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;

  typedef enum logic [1:0] {
    MEM_OP_NONE = 2'd0,
    MEM_OP_LW   = 2'd1,
    MEM_OP_SW   = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    MISS_WAIT = 2'd2,
    WR_REQ    = 2'd3
  } dcache_state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Direct-mapped valid/tag/data storage: combinational read, one synchronous write port.
module dcache_line_array #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_W      = 24,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid_c,
  output logic [TAG_W-1:0]      rd_tag_c,
  output logic [DATA_W-1:0]     rd_data_c,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int unsigned LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [DATA_W-1:0] data [LINES];

  // Only the valid bits are cleared; tag/data contents are don't-care until filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid_c = valid[rd_index];
  assign rd_tag_c   = tags[rd_index];
  assign rd_data_c  = data[rd_index];

endmodule

// File: rtl/dcache_resp.sv
// Direct-mapped write-through data-cache responder for the MEM stage.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_resp
  import dcache_resp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_mem_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 2;

  dcache_state_t state_q, state_d;
  mem_op_t       op;

  logic [INDEX_BITS-1:0] req_index, fill_index, wr_index;
  logic [TAG_W-1:0]      req_tag, fill_tag, line_tag, wr_tag;
  logic [DATA_W-1:0]     line_data, wr_data;
  logic                  line_valid, hit, wr_en;
  logic                  count_hit, count_miss;

  logic              req_ready_d, resp_valid_d, mem_req_valid_d, mem_req_we_d;
  logic [DATA_W-1:0] resp_rdata_d, mem_req_wdata_d;
  logic [ADDR_W-1:0] mem_req_addr_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign op         = mem_op_t'(req_mem_op);
  assign req_index  = req_addr[INDEX_BITS+1:2];
  assign req_tag    = req_addr[ADDR_W-1:INDEX_BITS+2];
  assign fill_index = mem_req_addr[INDEX_BITS+1:2];
  assign fill_tag   = mem_req_addr[ADDR_W-1:INDEX_BITS+2];
  assign hit        = line_valid && (line_tag == req_tag);

  dcache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .DATA_W     (DATA_W)
  ) u_lines (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (req_index),
    .rd_valid_c (line_valid),
    .rd_tag_c   (line_tag),
    .rd_data_c  (line_data),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_tag     (wr_tag),
    .wr_data    (wr_data)
  );

  // Next-state, array write port and next values of every registered output.
  always_comb begin
    state_d         = state_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = resp_rdata;
    mem_req_valid_d = 1'b0;
    mem_req_we_d    = mem_req_we;
    mem_req_addr_d  = mem_req_addr;
    mem_req_wdata_d = mem_req_wdata;
    wr_en           = 1'b0;
    wr_index        = req_index;
    wr_tag          = req_tag;
    wr_data         = req_wdata;
    count_hit       = 1'b0;
    count_miss      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && op == MEM_OP_LW) begin
          if (hit) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = line_data;
            count_hit    = 1'b1;
          end else begin
            mem_req_valid_d = 1'b1;
            mem_req_we_d    = 1'b0;
            mem_req_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            count_miss      = 1'b1;
            state_d         = MISS_REQ;
          end
        end else if (req_valid && op == MEM_OP_SW) begin
          // A store hit rewrites data with the same tag; a miss never allocates.
          wr_en           = hit;
          mem_req_valid_d = 1'b1;
          mem_req_we_d    = 1'b1;
          mem_req_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          mem_req_wdata_d = req_wdata;
          state_d         = WR_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid_d = !mem_req_ready;
        if (mem_req_ready) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (mem_resp_valid) begin
          wr_en        = 1'b1;
          wr_index     = fill_index;
          wr_tag       = fill_tag;
          wr_data      = mem_resp_rdata;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_resp_rdata;
          state_d      = IDLE;
        end
      end
      WR_REQ: begin
        mem_req_valid_d = !mem_req_ready;
        if (mem_req_ready) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      state_q       <= state_d;
      req_ready     <= req_ready_d;
      resp_valid    <= resp_valid_d;
      resp_rdata    <= resp_rdata_d;
      mem_req_valid <= mem_req_valid_d;
      mem_req_we    <= mem_req_we_d;
      mem_req_addr  <= mem_req_addr_d;
      mem_req_wdata <= mem_req_wdata_d;
    end
  end

`ifdef DCACHE_STATS_EN
  // Wrapping load hit/miss counters, bumped at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (count_hit)  hit_count  <= hit_count + 32'd1;
      if (count_miss) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_counts;
  assign unused_counts = count_hit ^ count_miss;
`endif

endmodule

// File: tb/tb_dcache_resp.sv
// Self-checking bench for dcache_resp: directed table, reset-in-miss sequence, random ops vs reference model.
module tb_dcache_resp;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_LW   = 2'd1;
  localparam logic [1:0] OP_SW   = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_mem_op;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_resp_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_resp dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_mem_op     (req_mem_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  // Reference model: what the requester has stored, plus which tag each index holds.
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] bus_mem [logic [29:0]];
  bit          pres_valid [64];
  logic [23:0] pres_tag   [64];
  logic [31:0] m_hits, m_misses;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    int          lat;
    logic [31:0] exp_rdata;
    int          exp_lat;
    bit          exp_mem;
    bit          exp_we;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] init_val(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  function automatic logic [31:0] bus_rd(input logic [29:0] w);
    return bus_mem.exists(w) ? bus_mem[w] : init_val(w);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) pres_valid[i] = 1'b0;
    m_hits   = '0;
    m_misses = '0;
  endfunction

  // Predicts one request's outcome and advances the model.
  function automatic void model_step(input logic [1:0] op, input logic [31:0] addr,
                                     input logic [31:0] wdata, input int stall, input int lat,
                                     output logic [31:0] exp_rdata, output int exp_lat,
                                     output bit exp_mem, output bit exp_we);
    int          idx;
    logic [23:0] tg;
    idx       = int'(addr[7:2]);
    tg        = addr[31:8];
    exp_rdata = '0;
    exp_lat   = 0;
    exp_mem   = 1'b0;
    exp_we    = 1'b0;
    if (op == OP_LW) begin
      exp_rdata = ref_rd(addr[31:2]);
      if (pres_valid[idx] && pres_tag[idx] == tg) begin
        exp_lat = 1;
        m_hits  = m_hits + 32'd1;
      end else begin
        exp_lat         = 2 + stall + lat;
        exp_mem         = 1'b1;
        pres_valid[idx] = 1'b1;
        pres_tag[idx]   = tg;
        m_misses        = m_misses + 32'd1;
      end
    end else if (op == OP_SW) begin
      ref_mem[addr[31:2]] = wdata;
      exp_lat = 2 + stall;
      exp_mem = 1'b1;
      exp_we  = 1'b1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_stats(input string name);
`ifdef DCACHE_STATS_EN
    chk({name, " hit_count"}, hit_count, m_hits);
    chk({name, " miss_count"}, miss_count, m_misses);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  // Issues one request, plays the backing memory, and checks response and bus traffic.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall, input int lat,
                        input logic [31:0] exp_rdata, input int exp_lat,
                        input bit exp_mem, input bit exp_we);
    int          cyc, stall_left, resp_in, nresp, nmem, got_lat;
    bit          inflight, unstable, rdy_bad;
    logic [31:0] got_rdata, m_addr, m_wdata;
    logic        m_we;
    @(negedge clk);
    chk({name, " req_ready before"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_mem_op = op;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
    req_mem_op = OP_NONE;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    cyc = 1; stall_left = stall; resp_in = 0; nresp = 0; nmem = 0; got_lat = 0;
    inflight = 1'b0; unstable = 1'b0; rdy_bad = 1'b0;
    got_rdata = '0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
    repeat ((exp_lat == 0) ? 6 : exp_lat + 4) begin
      if (resp_valid) begin
        nresp++;
        if (nresp == 1) begin
          got_lat   = cyc;
          got_rdata = resp_rdata;
        end
      end else if (nresp == 0 && exp_mem && req_ready) begin
        rdy_bad = 1'b1;
      end
      mem_resp_valid = 1'b0;
      if (resp_in > 0) begin
        resp_in--;
        if (resp_in == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = bus_rd(m_addr[31:2]);
        end
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (!inflight) begin
          inflight = 1'b1;
          m_addr   = mem_req_addr;
          m_we     = mem_req_we;
          m_wdata  = mem_req_wdata;
        end else if (mem_req_addr !== m_addr || mem_req_we !== m_we || mem_req_wdata !== m_wdata) begin
          unstable = 1'b1;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          inflight      = 1'b0;
          nmem++;
          if (mem_req_we) bus_mem[mem_req_addr[31:2]] = mem_req_wdata;
          else resp_in = lat;
        end
      end
      cyc++;
      @(negedge clk);
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    chk({name, " resp count"}, 32'(nresp), (exp_lat == 0) ? 32'd0 : 32'd1);
    if (exp_lat != 0) begin
      chk({name, " latency"}, 32'(got_lat), 32'(exp_lat));
      chk({name, " rdata"}, got_rdata, exp_rdata);
    end
    chk({name, " mem requests"}, 32'(nmem), exp_mem ? 32'd1 : 32'd0);
    if (exp_mem) begin
      chk({name, " mem addr"}, m_addr, {addr[31:2], 2'b00});
      chk({name, " mem we"}, 32'(m_we), 32'(exp_we));
      if (exp_we) chk({name, " mem wdata"}, m_wdata, wdata);
      chk({name, " mem stable"}, 32'(unstable), 32'd0);
      chk({name, " req_ready busy"}, 32'(rdy_bad), 32'd0);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                     input int stall, input int lat, input logic [31:0] er, input int el,
                     input bit em, input bit ew);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.stall = stall; v.lat = lat;
    v.exp_rdata = er; v.exp_lat = el; v.exp_mem = em; v.exp_we = ew;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] er;
    int          el;
    bit          em, ew;
    int          rcnt;

    rst = 1'b1; req_valid = 1'b0; req_mem_op = OP_NONE; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    ref_mem[30'h10] = 32'hDEAD_BEEF;
    bus_mem[30'h10] = 32'hDEAD_BEEF;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("reset mem_req_we", 32'(mem_req_we), 32'd0);
    chk("reset mem_req_addr", mem_req_addr, 32'd0);
    chk("reset mem_req_wdata", mem_req_wdata, 32'd0);
    chk_stats("reset");

    add(OP_LW,   32'h0000_0040, 32'h0,          0, 3, 32'hDEAD_BEEF, 5, 1, 0);
    add(OP_LW,   32'h0000_0040, 32'h0,          0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    add(OP_SW,   32'h0000_0040, 32'h1234_5678,  0, 1, 32'h0,         2, 1, 1);
    add(OP_LW,   32'h0000_0041, 32'h0,          0, 1, 32'h1234_5678, 1, 0, 0);
    add(OP_SW,   32'h0000_0140, 32'hCAFE_F00D,  1, 1, 32'h0,         3, 1, 1);
    add(OP_LW,   32'h0000_0040, 32'h0,          0, 1, 32'h1234_5678, 1, 0, 0);
    add(OP_NONE, 32'h0000_0040, 32'h0,          0, 1, 32'h0,         0, 0, 0);
    add(OP_LW,   32'h0000_0143, 32'h0,          0, 2, 32'hCAFE_F00D, 4, 1, 0);
    add(OP_LW,   32'h0000_0040, 32'h0,          0, 1, 32'h1234_5678, 3, 1, 0);
    add(OP_LW,   32'h0000_0080, 32'h0,          5, 2, init_val(30'h20), 9, 1, 0);

    foreach (tbl[i]) begin
      model_step(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].stall, tbl[i].lat, er, el, em, ew);
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].stall,
             tbl[i].lat, tbl[i].exp_rdata, tbl[i].exp_lat, tbl[i].exp_mem, tbl[i].exp_we);
      chk_stats($sformatf("tbl%0d", i));
    end

    // Reset while waiting for miss data; the late response must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_mem_op = OP_LW; req_addr = 32'h0000_0200;
    @(negedge clk);
    req_valid = 1'b0; req_mem_op = OP_NONE;
    chk("rstmiss mem_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rstmiss wait req_ready", 32'(req_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstmiss async req_ready", 32'(req_ready), 32'd1);
    chk("rstmiss async mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rstmiss async mem_req_addr", mem_req_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    rcnt = 0;
    repeat (4) begin
      if (resp_valid) rcnt++;
      @(negedge clk);
    end
    chk("rstmiss late resp", 32'(rcnt), 32'd0);
    model_clear();
    chk_stats("rstmiss");
    model_step(OP_LW, 32'h0000_0200, 32'h0, 0, 1, er, el, em, ew);
    run_op("rstmiss reload", OP_LW, 32'h0000_0200, 32'h0, 0, 1, er, el, em, ew);
    model_step(OP_LW, 32'h0000_0040, 32'h0, 0, 1, er, el, em, ew);
    run_op("rstmiss 0x40", OP_LW, 32'h0000_0040, 32'h0, 0, 1, er, el, em, ew);

    for (int i = 0; i < 250; i++) begin
      logic [1:0]  op;
      logic [31:0] addr, wdata;
      int          r, stall, lat;
      r     = int'($urandom_range(0, 9));
      op    = (r < 5) ? OP_LW : (r < 9) ? OP_SW : OP_NONE;
      addr  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2)
              | 32'($urandom_range(0, 3));
      wdata = $urandom;
      stall = int'($urandom_range(0, 3));
      lat   = int'($urandom_range(1, 4));
      model_step(op, addr, wdata, stall, lat, er, el, em, ew);
      run_op($sformatf("rnd%0d", i), op, addr, wdata, stall, lat, er, el, em, ew);
    end
    chk_stats("random end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
